teclado_cajero: RTL

Keypad front-end for the ATM controller. Converts raw key strobes into the controller's `digito`/`digito_stb` PIN-digit pulses and its `monto`/`monto_stb` amount word. Amount keys are accumulated as decimal into a binary word, with overflow protection. The block sits directly upstream of the controller and is driven by the physical keypad scanner.

---
 rtl/teclado_cajero.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/teclado_cajero.sv
// teclado_cajero
// ATM keypad front-end. It turns raw key strobes from the keypad scanner
// into PIN-digit pulses, or into a decimal amount that is accumulated
// into a binary word and committed on ENTER.
//
// Optional feature macro: TECLADO_TIMEOUT_EN
//   defined   -> an abandoned partial amount is discarded after
//                TIMEOUT_CICLOS idle cycles, and tiempo_agotado pulses.
//   undefined -> no idle counter is built, tiempo_agotado is tied to 0,
//                and a partial amount persists indefinitely.
//
// Parameters:
//   MONTO_W        width of the amount word
//   MAX_DIGITOS    maximum decimal digits accepted per amount
//   TIMEOUT_CICLOS idle cycles before a partial amount is dropped
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-low reset
//   tecla          key code: 0-9 digit, A = ENTER, B = BORRAR, C-F ignored
//   tecla_stb      one-cycle pulse marking tecla as valid
//   modo_monto     0 = PIN mode, 1 = amount mode
//   digito         last PIN digit emitted
//   digito_stb     one-cycle pulse marking digito as valid
//   monto          last committed amount; held until the next commit
//   monto_stb      one-cycle commit pulse
//   desborde       one-cycle pulse when an amount digit is rejected
//   tiempo_agotado one-cycle pulse when a partial amount times out
module teclado_cajero #(
  parameter int MONTO_W        = 32,
  parameter int MAX_DIGITOS    = 10,
  parameter int TIMEOUT_CICLOS = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         tecla,
  input  logic               tecla_stb,
  input  logic               modo_monto,
  output logic [3:0]         digito,
  output logic               digito_stb,
  output logic [MONTO_W-1:0] monto,
  output logic               monto_stb,
  output logic               desborde,
  output logic               tiempo_agotado
);

  localparam int CUENTA_W = $clog2(MAX_DIGITOS + 1);
  localparam int EXT_W    = MONTO_W + 4;

  localparam logic [3:0]          TECLA_ENTER  = 4'hA;
  localparam logic [3:0]          TECLA_BORRAR = 4'hB;
  localparam logic [CUENTA_W-1:0] CUENTA_MAX   = CUENTA_W'(MAX_DIGITOS);

  typedef enum logic [1:0] {
    ESPERA,
    ACUMULANDO,
    ENTREGA
  } estado_t;

  estado_t             estado, estado_n;
  logic [MONTO_W-1:0]  acc, acc_n;
  logic [CUENTA_W-1:0] cuenta, cuenta_n;
  logic [3:0]          digito_n;
  logic                digito_stb_n;
  logic [MONTO_W-1:0]  monto_n;
  logic                monto_stb_n;
  logic                desborde_n;

  logic                es_digito;
  logic [EXT_W-1:0]    acc_ext;
  logic [EXT_W-1:0]    nuevo;
  logic                cabe;

  // acc*10 + key, computed four bits wider than the amount word so that
  // an overflowing value shows up as nonzero bits above MONTO_W.
  always_comb begin
    acc_ext   = {4'b0000, acc};
    nuevo     = (acc_ext << 3) + (acc_ext << 1) + EXT_W'(tecla);
    es_digito = (tecla <= 4'd9);
    cabe      = (cuenta < CUENTA_MAX) && (nuevo[EXT_W-1:MONTO_W] == 4'b0000);
  end

`ifdef TECLADO_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CICLOS + 1);
  localparam logic [IDLE_W-1:0] IDLE_ULTIMO = IDLE_W'(TIMEOUT_CICLOS - 1);

  logic [IDLE_W-1:0] idle_cnt, idle_cnt_n;
  logic              tiempo_agotado_n;
`endif

  // Next-state and next-output logic. Later assignments take priority:
  // mode-leave discard and timeout are evaluated first, then the key
  // strobed this cycle, so a live key always wins over an idle timeout.
  always_comb begin
    estado_n     = estado;
    acc_n        = acc;
    cuenta_n     = cuenta;
    digito_n     = digito;
    digito_stb_n = 1'b0;
    monto_n      = monto;
    monto_stb_n  = 1'b0;
    desborde_n   = 1'b0;
`ifdef TECLADO_TIMEOUT_EN
    idle_cnt_n       = '0;
    tiempo_agotado_n = 1'b0;
`endif

    // The accumulator was already cleared on the way into ENTREGA, so a
    // key arriving now sees an empty amount, exactly as in ESPERA.
    if (estado == ENTREGA) begin
      estado_n = ESPERA;
    end

    // ACUMULANDO is only reachable with modo_monto high, so seeing it low
    // here means the caller has just switched back to PIN mode.
    if (estado == ACUMULANDO && !modo_monto) begin
      acc_n    = '0;
      cuenta_n = '0;
      estado_n = ESPERA;
    end

`ifdef TECLADO_TIMEOUT_EN
    if (estado == ACUMULANDO && modo_monto && !tecla_stb) begin
      if (idle_cnt == IDLE_ULTIMO) begin
        acc_n            = '0;
        cuenta_n         = '0;
        estado_n         = ESPERA;
        tiempo_agotado_n = 1'b1;
      end else begin
        idle_cnt_n = idle_cnt + IDLE_W'(1);
      end
    end
`endif

    if (tecla_stb) begin
      if (!modo_monto) begin
        if (es_digito) begin
          digito_n     = tecla;
          digito_stb_n = 1'b1;
        end
      end else if (es_digito) begin
        if (cabe) begin
          acc_n    = nuevo[MONTO_W-1:0];
          cuenta_n = cuenta + CUENTA_W'(1);
          estado_n = ACUMULANDO;
        end else begin
          desborde_n = 1'b1;
        end
      end else if (tecla == TECLA_ENTER) begin
        if (estado == ACUMULANDO) begin
          monto_n     = acc;
          monto_stb_n = 1'b1;
          acc_n       = '0;
          cuenta_n    = '0;
          estado_n    = ENTREGA;
        end
      end else if (tecla == TECLA_BORRAR) begin
        acc_n    = '0;
        cuenta_n = '0;
        estado_n = ESPERA;
      end
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      estado     <= ESPERA;
      acc        <= '0;
      cuenta     <= '0;
      digito     <= '0;
      digito_stb <= 1'b0;
      monto      <= '0;
      monto_stb  <= 1'b0;
      desborde   <= 1'b0;
    end else begin
      estado     <= estado_n;
      acc        <= acc_n;
      cuenta     <= cuenta_n;
      digito     <= digito_n;
      digito_stb <= digito_stb_n;
      monto      <= monto_n;
      monto_stb  <= monto_stb_n;
      desborde   <= desborde_n;
    end
  end

`ifdef TECLADO_TIMEOUT_EN
  // Idle counter and timeout pulse; the counter only advances in
  // ACUMULANDO and is forced back to zero everywhere else.
  always_ff @(posedge clk) begin
    if (!reset) begin
      idle_cnt       <= '0;
      tiempo_agotado <= 1'b0;
    end else begin
      idle_cnt       <= idle_cnt_n;
      tiempo_agotado <= tiempo_agotado_n;
    end
  end
`else
  assign tiempo_agotado = 1'b0;
`endif

endmodule
